// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, register-zero constant and counter width helper for pipeline_stall_ctrl
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction
endpackage

// File: rtl/mdu_stall_counter.sv
// mdu_stall_counter: loadable down-counter (clk, rst, load, load_val, en freezes, zero flag) timing MDU occupancy of EX
module mdu_stall_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= load ? load_val : (zero ? cnt : cnt - 1'b1);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard sequencer; hazard inputs (rs1D/rs2D/rdE/loadE/RegWriteE/PCSrcE/mdu_startE/imem_ready/dmem_ready) -> Stall F/D/E/M, Flush D/E/M
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rs1D,
  input  logic [RA_W-1:0] rs2D,
  input  logic [RA_W-1:0] rdE,
  input  logic            loadE,
  input  logic            RegWriteE,
  input  logic            PCSrcE,
  input  logic            mdu_startE,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM
);
  localparam int CW = cnt_w(MDU_LAT);
  state_t state, state_n;
  logic mem_wait, mw, act, lu, hold, br, start, lu_stall, zero;
  always_ff @(posedge clk) state <= rst ? RUN : state_n;
  always_comb begin
    mem_wait = !imem_ready || !dmem_ready;
    mw       = !rst && mem_wait;
    act      = !rst && !mem_wait;
    lu       = loadE && RegWriteE && rdE != RA_W'(REG_ZERO) && (rdE == rs1D || rdE == rs2D);
    hold     = act && state == MDU_WAIT && !zero;
    br       = act && !hold && PCSrcE;
    start    = act && state == RUN && !PCSrcE && mdu_startE;
    lu_stall = act && !hold && !PCSrcE && !start && lu;
    StallF   = mw || hold || start || lu_stall;
    StallD   = mw || hold || start || lu_stall;
    StallE   = mw || hold || start;
    StallM   = mw;
    FlushD   = rst || br;
    FlushE   = rst || br || lu_stall;
    FlushM   = rst || hold || start;
    state_n  = start ? MDU_WAIT : (act && state == MDU_WAIT && zero) ? RUN : state;
  end
  mdu_stall_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (CW'(MDU_LAT - 2)),
    .en       (!mem_wait),
    .zero     (zero)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench for pipeline_stall_ctrl at MDU_LAT=4 and MDU_LAT=2
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rdE;
  logic loadE, RegWriteE, PCSrcE, mdu_startE, imem_ready, dmem_ready;
  logic sf4, sd4, se4o, sm4, fd4, fe4, fm4;
  logic sf2, sd2, se2o, sm2, fd2, fe2, fm2;
  logic [6:0] o4, o2;
  logic [6:0] q4[$], q2[$];
  int checks = 0, errors = 0;
  int left4 = 0, left2 = 0, se4 = 0, se2 = 0;
  bit rel4 = 0, rel2 = 0;
  always #5 clk = ~clk;
  assign o4 = {sf4, sd4, se4o, sm4, fd4, fe4, fm4};
  assign o2 = {sf2, sd2, se2o, sm2, fd2, fe2, fm2};
  pipeline_stall_ctrl #(.MDU_LAT(4), .RA_W(5)) u4 (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE), .loadE(loadE),
    .RegWriteE(RegWriteE), .PCSrcE(PCSrcE), .mdu_startE(mdu_startE),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .StallF(sf4), .StallD(sd4), .StallE(se4o), .StallM(sm4),
    .FlushD(fd4), .FlushE(fe4), .FlushM(fm4)
  );
  pipeline_stall_ctrl #(.MDU_LAT(2), .RA_W(5)) u2 (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE), .loadE(loadE),
    .RegWriteE(RegWriteE), .PCSrcE(PCSrcE), .mdu_startE(mdu_startE),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .StallF(sf2), .StallD(sd2), .StallE(se2o), .StallM(sm2),
    .FlushD(fd2), .FlushE(fe2), .FlushM(fm2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] model(input int left, input bit rel);
    bit lu;
    lu = loadE && RegWriteE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
    if (rst) return 7'b0000_111;
    if (!imem_ready || !dmem_ready) return 7'b1111_000;
    if (left > 0) return 7'b1110_001;
    if (PCSrcE) return 7'b0000_110;
    if (!rel && mdu_startE) return 7'b1110_001;
    if (lu) return 7'b1100_010;
    return 7'b0000_000;
  endfunction
  task automatic upd(input int lat, inout int left, inout bit rel);
    if (rst) begin
      left = 0;
      rel = 0;
    end else if (imem_ready && dmem_ready) begin
      if (left > 0) left--;
      else if (rel) rel = 0;
      else if (!PCSrcE && mdu_startE) begin
        left = lat - 2;
        rel = 1;
      end
    end
  endtask
  task automatic cyc(input string tag);
    q4.push_back(model(left4, rel4));
    q2.push_back(model(left2, rel2));
    @(negedge clk);
    chk({tag, "_lat4"}, 32'(o4), 32'(q4.pop_front()));
    chk({tag, "_lat2"}, 32'(o2), 32'(q2.pop_front()));
    se4 += int'(se4o);
    se2 += int'(se2o);
    upd(4, left4, rel4);
    upd(2, left2, rel2);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rst = 0; rs1D = 0; rs2D = 0; rdE = 0; loadE = 0; RegWriteE = 0;
    PCSrcE = 0; mdu_startE = 0; imem_ready = 1; dmem_ready = 1;
  endtask
  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    cyc("reset");
    cyc("reset2");
    rst = 0;
    cyc("idle");
    loadE = 1; RegWriteE = 1; rdE = 5; rs1D = 5;
    cyc("lu_rs1");
    idle();
    cyc("lu_after");
    loadE = 1; RegWriteE = 1; rdE = 7; rs2D = 7;
    cyc("lu_rs2");
    loadE = 1; RegWriteE = 1; rdE = 0; rs1D = 0; rs2D = 0;
    cyc("lu_x0");
    loadE = 1; RegWriteE = 1; rdE = 5; rs1D = 5; PCSrcE = 1;
    cyc("branch_lu");
    idle();
    cyc("branch_after");
    se4 = 0; se2 = 0;
    mdu_startE = 1;
    repeat (4) cyc("mdu");
    chk("mdu_stalls_lat4", se4, 3);
    chk("mdu_stalls_lat2", se2, 2);
    idle();
    cyc("mdu_done");
    se4 = 0; se2 = 0;
    mdu_startE = 1;
    cyc("mw_start");
    cyc("mw_wait1");
    dmem_ready = 0;
    cyc("mw_dmem0");
    cyc("mw_dmem1");
    dmem_ready = 1;
    cyc("mw_wait2");
    cyc("mw_release");
    chk("memwait_stalls_lat4", se4, 5);
    chk("memwait_stalls_lat2", se2, 4);
    idle();
    cyc("mw_done");
    mdu_startE = 1;
    cyc("rst_start");
    cyc("rst_wait1");
    rst = 1;
    cyc("rst_mid");
    idle();
    cyc("rst_after");
    cyc("rst_after2");
    repeat (400) begin
      rst = ($urandom % 60) == 0;
      rs1D = 5'($urandom_range(0, 3));
      rs2D = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3));
      loadE = 1'($urandom);
      RegWriteE = 1'($urandom);
      PCSrcE = ($urandom % 4) == 0;
      mdu_startE = ($urandom % 3) != 0;
      imem_ready = 1'($urandom);
      dmem_ready = ($urandom % 5) != 0;
      cyc("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard/stall sequencer for the 5-stage RV32 pipeline.
- Drives the StallF enable of the PC register, plus the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves four hazard sources: load-use, taken branch/jump, multi-cycle MUL/DIV occupancy of EX, and instruction/data memory wait states.
- Combines small combinational detection with a sequential MDU wait state machine.

Parameters:
- MDU_LAT, 4, cycles an MDU instruction occupies EX; legal range 2..16.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rs1D  in  RA_W  source register 1 of the instruction in ID
- rs2D  in  RA_W  source register 2 of the instruction in ID
- rdE  in  RA_W  destination register of the instruction in EX
- loadE  in  1  instruction in EX is a load
- RegWriteE  in  1  instruction in EX writes the register file
- PCSrcE  in  1  branch taken or jump resolved in EX
- mdu_startE  in  1  instruction in EX is a multi-cycle MUL/DIV
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory has completed its access this cycle
- StallF  out  1  hold PC register
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM and MEM/WB registers
- FlushD  out  1  clear IF/ID to NOP
- FlushE  out  1  clear ID/EX to NOP
- FlushM  out  1  clear EX/MEM to NOP

Behaviour:
- Registered state:
  - state: RUN or MDU_WAIT.
  - cnt: $clog2(MDU_LAT) bits.
- Reset:
  - state=RUN, cnt=0.
  - While rst=1, outputs are forced: all Stall*=0, FlushD=FlushE=FlushM=1.
- Outputs are combinational from the state and inputs. Priority, highest first:
  1. MEM_WAIT (any state): imem_ready=0 or dmem_ready=0.
     - StallF=StallD=StallE=StallM=1; all flushes=0.
     - state and cnt hold.
     - A pending branch or MDU start is deferred, not lost, because EX is held.
  2. RUN, PCSrcE=1.
     - FlushD=1, FlushE=1, StallF=0 so the PC loads the target.
     - Overrides any load-use hazard in the same cycle.
  3. RUN, mdu_startE=1.
     - StallF=StallD=StallE=1, FlushM=1.
     - Next state MDU_WAIT, cnt<=MDU_LAT-2.
  4. RUN, load-use: loadE & RegWriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
     - StallF=StallD=1, FlushE=1.
     - Exactly one bubble.
  5. Otherwise all outputs are 0.
- MDU_WAIT, cnt!=0:
  - StallF=StallD=StallE=1, FlushM=1.
  - cnt<=cnt-1.
  - PCSrcE and load-use are not evaluated.
- MDU_WAIT, cnt==0:
  - Release cycle: EX advances. Rules 2 and 4 apply as in RUN; mdu_startE is ignored because it is the same instruction.
  - Next state RUN.
- MDU stall length: exactly MDU_LAT-1 cycles of StallE, counted from the first cycle mdu_startE is seen in RUN. MEM_WAIT cycles extend the length without consuming the count.
- Back-to-back MDU ops: the second op is detected in RUN on the cycle after the release cycle.
- Reset mid-MDU_WAIT: returns to RUN on the next edge, cnt=0.
- No output depends on any signal from a previous cycle except through state and cnt.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MDU_WAIT}.
  - Constant REG_ZERO=5'd0.
  - Function computing cnt width from MDU_LAT.
- Sub-module mdu_stall_counter: load, decrement, zero flag.
  - Ports: clk, rst, load, load_val, en, zero.
  - Freezes when en=0 (MEM_WAIT).
- Hazard detection stays inline.

Test Plan:
- Load-use: loadE=1, RegWriteE=1, rdE=5, rs1D=5 in RUN -> one cycle of StallF=StallD=FlushE=1. Same with rdE=0 -> no stall.
- Branch: PCSrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0, StallD=0 for one cycle.
- MDU, MDU_LAT=4: mdu_startE held while stalled -> StallE=1 for exactly 3 cycles, FlushM=1 for those 3 cycles, state back to RUN on the 4th edge. Repeat with MDU_LAT=2 -> 1 stall cycle.
- Memory wait during MDU: dmem_ready=0 for 2 cycles in the middle of MDU_WAIT -> all Stall*=1, cnt frozen, total StallE cycles = 5 for MDU_LAT=4.
- Reset mid-op: assert rst in the 2nd MDU_WAIT cycle -> outputs show stalls 0 and flushes 1 while rst is high; after deassert, state=RUN and no residual stall.
- Back-to-back MDU ops with imem_ready toggling randomly -> each op gives MDU_LAT-1 non-wait stall cycles, and PCSrcE is never acted on while StallE=1 due to MDU.
